// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// Shared constants and the state encoding for the serial BCD adder controller.
package bcd_serial_adder_ctrl_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;
  localparam logic [3:0] BCD_CORR    = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A nibble above 9 is not a legal BCD digit.
  function automatic logic digit_bad(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_serial_adder_ctrl_if.sv
// Operand/result handshake bundle between producers, the controller and consumers.
interface bcd_serial_adder_ctrl_if #(
  parameter int DIGITS = 4
);
  import bcd_serial_adder_ctrl_pkg::*;

  localparam int W = BCD_DIGIT_W * DIGITS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         co;
  logic         err;
  logic         busy;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, co, err, busy
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, co, err, busy
  );

endinterface

// File: rtl/bcd_serial_adder_ctrl_digit_add.sv
// Single-digit BCD adder with decimal carry; time-shared across digits by the controller.
module bcd_digit_add
  import bcd_serial_adder_ctrl_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] t;

  // Binary sum then +6 correction when the digit overflows past 9.
  always_comb begin
    t = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    if (t > {1'b0, BCD_MAX}) begin
      s  = t[3:0] + BCD_CORR;
      co = 1'b1;
    end else begin
      s  = t[3:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Serial packed-BCD add/subtract controller: one digit per clock, LSD first.
// Subtraction is A + nines'(B) + 1; the final carry is inverted into a borrow.
module bcd_serial_adder_ctrl
  import bcd_serial_adder_ctrl_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input logic                    clk,
  input logic                    rst,
  bcd_serial_adder_ctrl_if.slave bus
);

  localparam int W     = BCD_DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               sub_q, sub_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               co_q, co_d;
  logic               err_q, err_d;

  logic               in_bad;
  logic [3:0]         dig_a, dig_b, dig_s;
  logic               dig_co;

  // Flag any non-BCD nibble in the presented operands.
  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_bad(bus.a[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
          digit_bad(bus.b[i*BCD_DIGIT_W +: BCD_DIGIT_W]))
        in_bad = 1'b1;
    end
  end

  // Select the current digit pair; B is nines'-complemented when subtracting.
  always_comb begin
    dig_a = a_q[int'(idx_q)*BCD_DIGIT_W +: BCD_DIGIT_W];
    dig_b = b_q[int'(idx_q)*BCD_DIGIT_W +: BCD_DIGIT_W];
    if (sub_q) dig_b = BCD_MAX - dig_b;
  end

  bcd_digit_add u_digit_add (
    .a  (dig_a),
    .b  (dig_b),
    .ci (carry_q),
    .s  (dig_s),
    .co (dig_co)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    co_d    = co_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = bus.sub;
          idx_d   = '0;
          carry_d = bus.sub;
          sum_d   = '0;
          co_d    = 1'b0;
          err_d   = in_bad;
          state_d = in_bad ? ST_DONE : ST_ADD;
        end
      end
      ST_ADD: begin
        sum_d[int'(idx_q)*BCD_DIGIT_W +: BCD_DIGIT_W] = dig_s;
        carry_d = dig_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          co_d    = sub_q ? ~dig_co : dig_co;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.sum       = sum_q;
  assign bus.co        = co_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed bench for bcd_serial_adder_ctrl with a decimal-arithmetic reference model.
module tb_bcd_serial_adder_ctrl;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bcd_serial_adder_ctrl_if #(.DIGITS(D)) bus ();

  bcd_serial_adder_ctrl #(.DIGITS(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_sum = '0;
  logic         exp_co  = 1'b0;
  logic         exp_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decode to integers, do decimal arithmetic, re-encode.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] r, output logic c, output logic e);
    int va, vb, vr, p, modv;
    logic bad;
    va = 0; vb = 0; p = 1; bad = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (a[i*4 +: 4] > 4'd9 || b[i*4 +: 4] > 4'd9) bad = 1'b1;
      va += int'(a[i*4 +: 4]) * p;
      vb += int'(b[i*4 +: 4]) * p;
      p  *= 10;
    end
    modv = p;
    r = '0; c = 1'b0; e = bad;
    if (bad) return;
    if (!s) begin
      vr = va + vb;
      c  = (vr >= modv);
      vr = vr % modv;
    end else begin
      c  = (va < vb);
      vr = c ? modv + va - vb : va - vb;
    end
    for (int i = 0; i < D; i++) begin
      r[i*4 +: 4] = 4'(vr % 10);
      vr /= 10;
    end
  endfunction

  // Every cycle: busy/in_ready consistency, and results against the model while valid.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_vs_in_ready", {31'b0, bus.busy}, {31'b0, ~bus.in_ready});
      if (bus.out_valid) begin
        chk("model_sum", {16'b0, bus.sum}, {16'b0, exp_sum});
        chk("model_co",  {31'b0, bus.co},  {31'b0, exp_co});
        chk("model_err", {31'b0, bus.err}, {31'b0, exp_err});
      end
    end
  end

  // Called at a negedge; returns 1ns after the accepting edge.
  task automatic start_op(input logic [W-1:0] a_i, input logic [W-1:0] b_i, input logic s_i);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'b0, bus.in_ready}, 32'd1);
    model(a_i, b_i, s_i, exp_sum, exp_co, exp_err);
    bus.a = a_i;
    bus.b = b_i;
    bus.sub = s_i;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 50);
  endtask

  // Accept the result; controller must be back in IDLE right after.
  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("drain_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("drain_in_ready",  {31'b0, bus.in_ready},  32'd1);
    @(negedge clk);
  endtask

  task automatic op(input string name, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                    input logic s_i, input logic [W-1:0] l_sum, input logic l_co,
                    input logic l_err, input int l_lat);
    int lat;
    start_op(a_i, b_i, s_i);
    wait_result(lat);
    chk({name, "_lat"}, 32'(lat), 32'(l_lat));
    chk({name, "_sum"}, {16'b0, bus.sum}, {16'b0, l_sum});
    chk({name, "_co"},  {31'b0, bus.co},  {31'b0, l_co});
    chk({name, "_err"}, {31'b0, bus.err}, {31'b0, l_err});
    drain();
  endtask

  initial begin
    logic [W-1:0] held;
    int lat;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_sum",       {16'b0, bus.sum},       32'd0);
    chk("rst_co",        {31'b0, bus.co},        32'd0);
    chk("rst_err",       {31'b0, bus.err},       32'd0);
    chk("rst_busy",      {31'b0, bus.busy},      32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 5);
    op("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 5);
    op("sub_0500_0123", 16'h0500, 16'h0123, 1'b1, 16'h0377, 1'b0, 1'b0, 5);
    op("sub_0123_0500", 16'h0123, 16'h0500, 1'b1, 16'h9623, 1'b1, 1'b0, 5);
    op("bad_a_12A4",    16'h12A4, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1);
    op("bad_b_F000",    16'h0000, 16'hF000, 1'b1, 16'h0000, 1'b0, 1'b1, 1);
    op("add_9999_9999", 16'h9999, 16'h9999, 1'b0, 16'h9998, 1'b1, 1'b0, 5);
    op("sub_0000_0001", 16'h0000, 16'h0001, 1'b1, 16'h9999, 1'b1, 1'b0, 5);
    op("sub_5555_5555", 16'h5555, 16'h5555, 1'b1, 16'h0000, 1'b0, 1'b0, 5);
    op("add_0000_0000", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 5);

    // Backpressure: result held, new operands ignored.
    start_op(16'h0999, 16'h0001, 1'b0);
    wait_result(lat);
    chk("bp_lat", 32'(lat), 32'd5);
    chk("bp_sum", {16'b0, bus.sum}, 32'h1000);
    held = bus.sum;
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.sub = 1'b1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_hold_sum",   {16'b0, bus.sum},       {16'b0, held});
      chk("bp_hold_co",    {31'b0, bus.co},        32'd0);
      chk("bp_in_ready",   {31'b0, bus.in_ready},  32'd0);
    end
    bus.in_valid = 1'b0;
    drain();
    chk("bp_not_accepted", {31'b0, bus.busy}, 32'd0);

    // Reset while digit 2 is being added.
    start_op(16'h1234, 16'h5678, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("mid_add_busy", {31'b0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_in_ready",  {31'b0, bus.in_ready},  32'd1);
    chk("mrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("mrst_sum",       {16'b0, bus.sum},       32'd0);
    chk("mrst_busy",      {31'b0, bus.busy},      32'd0);
    rst = 1'b0;
    @(negedge clk);
    op("post_rst_add", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 5);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
